trng_multi_ro_core: RTL and testbench
=====================================

// Module: trng_multi_ro_core
// PURPOSE
//  Multi-ring-oscillator TRNG core. It samples NUM_RO free-running oscillator
//  outputs and XOR-combines them into one raw bit. An optional von Neumann
//  debiaser follows, then the bits are packed into WORD_W-bit words and
//  offered on a valid/ready port.
//  A repetition-count health test watches the raw stream. The core sits
//  between the ring_oscillator instances and the tile's uo_out/uio logic.
// PARAMETERS
//  NUM_RO      4   number of oscillator inputs XORed together (>=1)
//  WORD_W      8   output word width in bits (>=2)
//  SAMPLE_DIV  4   sample one raw bit every SAMPLE_DIV clk cycles (>=1)
//  WARMUP      16  raw samples discarded after leaving IDLE (>=0)
//  RCT_LIMIT   32  identical consecutive raw samples that declare failure (>=2)
// PORTS
//  clk          in   1           core clock
//  rst          in   1           synchronous, active-high reset
//  en           in   1           run request; level-sensitive
//  ro_bits      in   NUM_RO      asynchronous oscillator outputs
//  ro_enable    out  1           enable to oscillators; 1 in WARMUP/RUN only
//  out_data     out  WORD_W      packed random word; first bit collected is the MSB
//  out_valid    out  1           out_data holds a complete word
//  out_ready    in   1           consumer accepts when out_valid&&out_ready
//  health_fail  out  1           sticky repetition-count failure flag
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset rst is synchronous and active-high.
//    On reset: ro_enable=0, out_valid=0, out_data=0, health_fail=0, state=IDLE,
//    and all counters, synchronisers and the pair register are cleared.
//  - Input path: each ro_bits[i] passes through a 2-flop synchroniser.
//    raw = XOR of the synchronised bits.
//  - Sampling: a divider counter runs 0..SAMPLE_DIV-1 while in WARMUP/RUN.
//    A sample strobe fires when the counter wraps to 0. SAMPLE_DIV=1 strobes
//    every cycle. The counter is held at 0 in IDLE/FAIL.
//  - FSM:
//    - IDLE: en=1 -> WARMUP. ro_enable rises the next cycle.
//    - WARMUP: counts WARMUP strobes, discarding them -> RUN. WARMUP=0 goes
//      to RUN after one cycle.
//    - RUN: strobed bits feed the packer.
//    - en=0 in WARMUP/RUN -> IDLE. This clears the bit count, pair register
//      and out_valid; a pending word is dropped.
//    - FAIL: entered from WARMUP or RUN. Exit only via rst; en is ignored.
//  - Health test (RCT): runs on every strobe in WARMUP and RUN, before any
//    debiasing.
//    - run_len resets to 1 when the sample differs from the previous sample,
//      and increments otherwise. It saturates at RCT_LIMIT.
//    - When run_len reaches RCT_LIMIT: health_fail=1 and state=FAIL on the
//      next edge. In the same edge out_valid is forced to 0 and ro_enable to 0.
//  - Packing:
//    - Accepted bits shift in from the LSB.
//    - After WORD_W accepted bits, out_data loads and out_valid=1 on the
//      following edge.
//    - The packer restarts at 0 bits. Collection of the next word continues
//      while out_valid is high.
//    - If a new word completes while out_valid&&!out_ready, the new word is
//      discarded and out_data is kept (no overwrite).
//    - Overrun is silent. out_data is stable whenever out_valid=1.
//  - Handshake: out_valid falls the cycle after out_valid&&out_ready. When a
//    word completes in the same cycle as the handshake, out_valid stays 1 and
//    out_data takes the new word.
// CONFIGURATION
//  - TRNG_VN_DEBIAS_EN defined: strobed bits in RUN are paired
//    (first,second): 01->accept 0, 10->accept 1, 00/11->discard both.
//    The pair register clears when leaving RUN.
//  - TRNG_VN_DEBIAS_EN undefined: every strobed bit in RUN is accepted
//    directly. There is no pair register.
//  - The RCT is unaffected by the macro in both builds.
// TESTING
//  1. Reset with NUM_RO=1, SAMPLE_DIV=1, WARMUP=0, no debias; drive ro_bits
//     constant-1 then toggle -> all outputs 0 during rst; first word after 8
//     accepted bits matches the 2-cycle-delayed input pattern.
//  2. Drive alternating 1,0 per strobe, en=1, out_ready=0 -> out_valid=1 with
//     out_data=8'hAA (MSB first) held stable. Later words are dropped until
//     out_ready pulses.
//  3. Hold ro_bits constant for 32 strobes (RCT_LIMIT=32) -> health_fail=1 on
//     the strobe that gives run_len 32, plus ro_enable=0 and out_valid=0. en
//     toggling has no effect until rst.
//  4. With TRNG_VN_DEBIAS_EN: raw pairs 01,11,10,00,10 -> accepted bits
//     0,1,1 only; a 3-bit partial word is held in the packer.
//  5. Drop en mid-word after 5 accepted bits -> IDLE; re-enable with WARMUP=16
//     -> the first 16 strobes are ignored and a full fresh 8 bits are needed
//     for a word.
//  6. Complete a word in the same cycle as out_valid&&out_ready -> out_valid
//     stays 1 and out_data updates with no gap cycle.

Source files
------------

// File: rtl/trng_multi_ro_core.sv
// -----------------------------------------------------------------------------
// trng_multi_ro_core
//
// Purpose:
//   Multi-ring-oscillator TRNG core. NUM_RO asynchronous oscillator outputs are
//   synchronised and XOR-combined into one raw bit. That bit is sampled every
//   SAMPLE_DIV cycles and watched by a repetition-count health test. In RUN the
//   samples are optionally von Neumann debiased and then packed MSB-first into
//   WORD_W-bit words, which are offered on a valid/ready port.
//
// Optional feature:
//   TRNG_VN_DEBIAS_EN  when defined, RUN samples are paired: 01 -> 0,
//                      10 -> 1, and 00/11 are discarded. When undefined,
//                      every RUN sample is accepted and no pair register
//                      exists.
//
// Ports:
//   clk          core clock
//   rst          synchronous, active-high reset
//   en           run request (level)
//   ro_bits      asynchronous oscillator outputs
//   ro_enable    oscillator enable, high in WARMUP/RUN only
//   out_data     packed word; the first bit collected is the MSB
//   out_valid    out_data holds a complete word
//   out_ready    consumer accepts when out_valid && out_ready
//   health_fail  sticky repetition-count failure flag
// -----------------------------------------------------------------------------
module trng_multi_ro_core #(
  parameter int NUM_RO     = 4,
  parameter int WORD_W     = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP     = 16,
  parameter int RCT_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_RO-1:0] ro_bits,
  output logic              ro_enable,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int RUN_W  = $clog2(RCT_LIMIT + 1);
  localparam int BIT_W  = $clog2(WORD_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(RCT_LIMIT);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  state_t              state_reg;
  logic                ro_enable_reg;
  logic [WORD_W-1:0]   out_data_reg;
  logic                out_valid_reg;
  logic                health_fail_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [WARM_W-1:0]   warm_cnt_reg;
  logic [RUN_W-1:0]    run_len_reg;
  logic                prev_sample_reg;
  logic [WORD_W-1:0]   shift_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
`ifdef TRNG_VN_DEBIAS_EN
  logic                pair_valid_reg;
  logic                pair_bit_reg;
`endif

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser per oscillator input
  // ---------------------------------------------------------------------------
  logic [NUM_RO-1:0] sync_bits;

  for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= ro_bits[gi];
        s2_reg <= s1_reg;
      end
    end
    assign sync_bits[gi] = s2_reg;
  end

  logic raw;
  assign raw = ^sync_bits;

  // ---------------------------------------------------------------------------
  // Sample strobe, health test and accepted-bit selection
  // ---------------------------------------------------------------------------
  logic             active;
  logic             strobe;
  logic [RUN_W-1:0] run_len_next;
  logic             rct_trip;
  logic             accept_valid;
  logic             accept_bit;
  logic             word_done;
  logic [WORD_W-1:0] shift_next;

  assign active = (state_reg == S_WARMUP) || (state_reg == S_RUN);
  // The divider wraps to 0 on the cycle it sits at its last value.
  assign strobe = active && (div_cnt_reg == DIV_LAST);

  always_comb begin
    run_len_next = run_len_reg;
    if (raw != prev_sample_reg) begin
      run_len_next = RUN_W'(1);
    end else if (run_len_reg != RUN_MAX) begin
      run_len_next = run_len_reg + 1'b1;
    end
  end

  assign rct_trip = strobe && (run_len_next == RUN_MAX);

  always_comb begin
    accept_valid = 1'b0;
    accept_bit   = raw;
    if ((state_reg == S_RUN) && strobe) begin
`ifdef TRNG_VN_DEBIAS_EN
      // Second sample of a pair: an unequal pair yields its first bit.
      if (pair_valid_reg && (pair_bit_reg != raw)) begin
        accept_valid = 1'b1;
        accept_bit   = pair_bit_reg;
      end
`else
      accept_valid = 1'b1;
`endif
    end
  end

  assign shift_next = {shift_reg[WORD_W-2:0], accept_bit};
  assign word_done  = accept_valid && (bit_cnt_reg == BIT_LAST);

  // ---------------------------------------------------------------------------
  // Control FSM, health state and packer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      ro_enable_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_valid_reg   <= 1'b0;
      health_fail_reg <= 1'b0;
      div_cnt_reg     <= '0;
      warm_cnt_reg    <= '0;
      run_len_reg     <= '0;
      prev_sample_reg <= 1'b0;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
`ifdef TRNG_VN_DEBIAS_EN
      pair_valid_reg  <= 1'b0;
      pair_bit_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          div_cnt_reg <= '0;
          if (en) begin
            state_reg     <= S_WARMUP;
            ro_enable_reg <= 1'b1;
            warm_cnt_reg  <= '0;
          end
        end

        S_WARMUP, S_RUN: begin
          div_cnt_reg <= strobe ? '0 : div_cnt_reg + 1'b1;
          if (strobe) begin
            prev_sample_reg <= raw;
            run_len_reg     <= run_len_next;
          end

          if (rct_trip) begin
            // Health failure wins over everything, including en=0.
            state_reg       <= S_FAIL;
            health_fail_reg <= 1'b1;
            ro_enable_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            div_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_valid_reg  <= 1'b0;
`endif
          end else if (!en) begin
            // Abort: any partial or pending word is dropped.
            state_reg       <= S_IDLE;
            ro_enable_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            div_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_valid_reg  <= 1'b0;
`endif
          end else if (state_reg == S_WARMUP) begin
            if (WARMUP == 0) begin
              state_reg <= S_RUN;
            end else if (strobe) begin
              if (warm_cnt_reg == WARM_LAST) begin
                state_reg <= S_RUN;
              end else begin
                warm_cnt_reg <= warm_cnt_reg + 1'b1;
              end
            end
          end else begin
            if (out_valid_reg && out_ready) begin
              out_valid_reg <= 1'b0;
            end
`ifdef TRNG_VN_DEBIAS_EN
            if (strobe) begin
              pair_valid_reg <= !pair_valid_reg;
              if (!pair_valid_reg) begin
                pair_bit_reg <= raw;
              end
            end
`endif
            if (accept_valid) begin
              shift_reg <= shift_next;
              if (word_done) begin
                bit_cnt_reg <= '0;
                // A word finishing while the previous one is still unread
                // is discarded so out_data never changes under out_valid.
                if (!out_valid_reg || out_ready) begin
                  out_data_reg  <= shift_next;
                  out_valid_reg <= 1'b1;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
        end

        default: begin
          // S_FAIL: locked until reset.
          div_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign ro_enable   = ro_enable_reg;
  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;
  assign health_fail = health_fail_reg;

endmodule

// File: tb/tb_trng_multi_ro_core.sv
// -----------------------------------------------------------------------------
// tb_trng_multi_ro_core
//
// Directed bench for trng_multi_ro_core with NUM_RO=1, SAMPLE_DIV=1,
// WORD_W=8, RCT_LIMIT=32. Two instances share all inputs: dut (WARMUP=0) and
// dut_w (WARMUP=16). With SAMPLE_DIV=1 a bit driven before edge k is sampled
// at edge k+2; with WARMUP=0 and en raised before edge E the first packed bit
// is the one driven before edge E.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trng_multi_ro_core;

  logic       clk;
  logic       rst;
  logic       en;
  logic [0:0] ro_bits;
  logic       out_ready;

  logic       ro_enable0, out_valid0, health_fail0;
  logic [7:0] out_data0;
  logic       ro_enable1, out_valid1, health_fail1;
  logic [7:0] out_data1;

  int tests_run = 0;
  int tests_failed = 0;

  trng_multi_ro_core #(
    .NUM_RO(1), .WORD_W(8), .SAMPLE_DIV(1), .WARMUP(0), .RCT_LIMIT(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ro_bits(ro_bits),
    .ro_enable(ro_enable0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .health_fail(health_fail0)
  );

  trng_multi_ro_core #(
    .NUM_RO(1), .WORD_W(8), .SAMPLE_DIV(1), .WARMUP(16), .RCT_LIMIT(32)
  ) dut_w (
    .clk(clk), .rst(rst), .en(en), .ro_bits(ro_bits),
    .ro_enable(ro_enable1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .health_fail(health_fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive one oscillator bit, advance one clock, settle past the edge.
  task automatic tick(input logic b);
    ro_bits = b;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    rst = 1'b0;
  endtask

  logic [31:0] stim;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    ro_bits = 1'b1;

    // ---- reset state ----
    do_reset();
    rst = 1'b1;
    tick(1'b1);
    check_eq("rst_ro_enable", {31'd0, ro_enable0}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data0}, 32'd0);
    check_eq("rst_health_fail", {31'd0, health_fail0}, 32'd0);
    rst = 1'b0;
    tick(1'b0);
    tick(1'b0);
    check_eq("idle_ro_enable", {31'd0, ro_enable0}, 32'd0);

`ifndef TRNG_VN_DEBIAS_EN
    // ---- first word follows the delayed input pattern ----
    en = 1'b1;
    stim = {22'd0, 8'hCA, 2'b01};
    for (int i = 0; i < 10; i++) begin
      tick(stim[9 - i]);
      if (i == 0) check_eq("t1_ro_enable_rise", {31'd0, ro_enable0}, 32'd1);
      if (i == 8) check_eq("t1_valid_early", {31'd0, out_valid0}, 32'd0);
      if (i == 9) begin
        check_eq("t1_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t1_data", {24'd0, out_data0}, 32'h0000_00CA);
      end
    end
    go_idle();
    check_eq("t1_idle_valid", {31'd0, out_valid0}, 32'd0);

    // ---- AA held with out_ready=0, next word dropped ----
    en = 1'b1;
    out_ready = 1'b0;
    stim = {14'd0, 8'hAA, 8'h33, 2'b10};
    for (int i = 0; i < 18; i++) begin
      tick(stim[17 - i]);
      if (i == 9) begin
        check_eq("t2_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t2_data", {24'd0, out_data0}, 32'h0000_00AA);
      end
      if (i == 17) begin
        check_eq("t2_hold_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t2_hold_data", {24'd0, out_data0}, 32'h0000_00AA);
      end
    end
    out_ready = 1'b1;
    tick(1'b0);
    out_ready = 1'b0;
    check_eq("t2_valid_after_ready", {31'd0, out_valid0}, 32'd0);
    go_idle();

    // ---- word completes on the handshake cycle ----
    en = 1'b1;
    stim = {14'd0, 8'h96, 8'h3C, 2'b01};
    for (int i = 0; i < 18; i++) begin
      if (i == 17) out_ready = 1'b1;
      tick(stim[17 - i]);
      if (i == 9) check_eq("t6_first_data", {24'd0, out_data0}, 32'h0000_0096);
      if (i == 16) check_eq("t6_held_data", {24'd0, out_data0}, 32'h0000_0096);
      if (i == 17) begin
        check_eq("t6_valid_kept", {31'd0, out_valid0}, 32'd1);
        check_eq("t6_new_data", {24'd0, out_data0}, 32'h0000_003C);
      end
    end
    tick(1'b1);
    out_ready = 1'b0;
    check_eq("t6_valid_drop", {31'd0, out_valid0}, 32'd0);
    go_idle();

    // ---- abort mid-word, then warm-up on re-enable ----
    en = 1'b1;
    stim = {25'd0, 7'b1011001};
    for (int i = 0; i < 7; i++) tick(stim[6 - i]);
    en = 1'b0;
    tick(1'b0);
    check_eq("t5_abort_valid", {31'd0, out_valid0}, 32'd0);
    tick(1'b0);
    en = 1'b1;
    stim = {7'd0, 15'h5555, 8'hC3, 2'b01};
    for (int i = 0; i < 25; i++) begin
      tick(stim[24 - i]);
      if (i == 0) check_eq("t5_w_ro_enable", {31'd0, ro_enable1}, 32'd1);
      if (i == 8) check_eq("t5_fresh_valid_early", {31'd0, out_valid0}, 32'd0);
      if (i == 9) check_eq("t5_fresh_data", {24'd0, out_data0}, 32'h0000_00AA);
      if (i == 23) check_eq("t5_w_valid_early", {31'd0, out_valid1}, 32'd0);
      if (i == 24) begin
        check_eq("t5_w_valid", {31'd0, out_valid1}, 32'd1);
        check_eq("t5_w_data", {24'd0, out_data1}, 32'h0000_00C3);
      end
    end
    go_idle();
`else
    // ---- von Neumann pairs 01,11,10,00,10 then 10,01,10,10,01 ----
    en = 1'b1;
    stim = {10'd0, 10'b0111100010, 10'b1001101001, 2'b00};
    for (int i = 0; i < 22; i++) begin
      tick(stim[21 - i]);
      if (i == 20) check_eq("t4_partial_valid", {31'd0, out_valid0}, 32'd0);
      if (i == 21) begin
        check_eq("t4_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t4_data", {24'd0, out_data0}, 32'h0000_0076);
      end
    end
    go_idle();
`endif

    // ---- repetition-count failure ----
    do_reset();
    ro_bits = 1'b1;
    tick(1'b1);
    en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick(1'b1);
      if (i == 31) begin
        check_eq("t3_no_fail_yet", {31'd0, health_fail0}, 32'd0);
`ifndef TRNG_VN_DEBIAS_EN
        check_eq("t3_valid_before", {31'd0, out_valid0}, 32'd1);
`endif
      end
      if (i == 32) begin
        check_eq("t3_health_fail", {31'd0, health_fail0}, 32'd1);
        check_eq("t3_ro_enable", {31'd0, ro_enable0}, 32'd0);
        check_eq("t3_valid", {31'd0, out_valid0}, 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      tick(i[1]);
    end
    check_eq("t3_sticky_fail", {31'd0, health_fail0}, 32'd1);
    check_eq("t3_stuck_ro_enable", {31'd0, ro_enable0}, 32'd0);
    check_eq("t3_stuck_valid", {31'd0, out_valid0}, 32'd0);
    do_reset();
    check_eq("t3_rst_clears_fail", {31'd0, health_fail0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
